imem_boot_loader: RTL

Writer-side counterpart of the pipeline's instruction memory: receives a program image as a byte stream over a valid/ready interface, packs it into 32-bit words, and writes them into instruction memory at byte addresses 0, 4, 8, … . Holds the MIPS pipeline in reset until a complete, checksum-verified image is loaded, then releases it so fetch starts at PC = 0.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/byte_word_packer.sv | 43 ++++
 rtl/imem_boot_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_pkg;

  localparam int BOOT_CNT_W = 16;
  localparam int INSTR_W    = 32;

  typedef enum logic [2:0] {
    BS_IDLE,
    BS_LEN_HI,
    BS_LEN_LO,
    BS_DATA,
    BS_CSUM,
    BS_DONE,
    BS_ERROR
  } boot_state_t;

  function automatic logic is_rx_state(boot_state_t s);
    return (s == BS_LEN_HI) || (s == BS_LEN_LO) || (s == BS_DATA) || (s == BS_CSUM);
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs big-endian bytes into 32-bit words; pulses word_vld_o with the 4th byte.
module byte_word_packer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               byte_vld_i,
  input  logic [7:0]         byte_i,
  output logic               word_vld_o,
  output logic [INSTR_W-1:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr_i) begin
      cnt_d = 2'd0;
      sr_d  = 24'd0;
    end else if (byte_vld_i) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {sr_q[15:0], byte_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 2'd0;
      sr_q  <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  // Word is presented combinationally with the 4th byte; the top registers it.
  assign word_vld_o = byte_vld_i & ~clr_i & (cnt_q == 2'd3);
  assign word_o     = {sr_q, byte_i};

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and holds the CPU in reset until a verified image is present.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   LEN_HI | receiving word-count MSB
//   LEN_LO | receiving word-count LSB, range check
//   DATA   | receiving payload bytes, writing words
//   CSUM   | receiving checksum byte
//   DONE   | image verified, CPU released
//   ERROR  | oversize or checksum mismatch, CPU held
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = BOOT_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               wr_en,
  output logic [31:0]        wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_reset_n,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   words_loaded
);

  boot_state_t state_q, state_d;

  logic [7:0]         len_hi_q, len_hi_d;
  logic [17:0]        rem_q, rem_d;
  logic [7:0]         csum_q, csum_d;
  logic [31:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;

  logic [15:0]        len_w;
  logic               accept;
  logic               start_go;
  logic               word_vld;
  logic [INSTR_W-1:0] word;

  assign len_w    = {len_hi_q, rx_data};
  assign accept   = rx_valid & rx_ready;
  assign start_go = start & ((state_q == BS_IDLE) || (state_q == BS_DONE) || (state_q == BS_ERROR));

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (start_go),
    .byte_vld_i (accept & (state_q == BS_DATA)),
    .byte_i     (rx_data),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= BS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BS_IDLE, BS_DONE, BS_ERROR: if (start) state_d = BS_LEN_HI;
      BS_LEN_HI: if (accept) state_d = BS_LEN_LO;
      BS_LEN_LO: begin
        if (accept) begin
          if ({16'd0, len_w} > DEPTH) state_d = BS_ERROR;
          else if (len_w == 16'd0)    state_d = BS_CSUM;
          else                        state_d = BS_DATA;
        end
      end
      BS_DATA: if (accept && (rem_q == 18'd1)) state_d = BS_CSUM;
      BS_CSUM: if (accept) state_d = (csum_q == rx_data) ? BS_DONE : BS_ERROR;
      default: state_d = BS_IDLE;
    endcase
  end

  always_comb begin
    rx_ready    = is_rx_state(state_q);
    busy        = is_rx_state(state_q);
    done        = (state_q == BS_DONE);
    error       = (state_q == BS_ERROR);
    cpu_reset_n = (state_q == BS_DONE);
  end

  // rem_q counts payload bytes still expected; DATA ends on terminal count 1.
  always_comb begin
    len_hi_d  = len_hi_q;
    rem_d     = rem_q;
    csum_d    = csum_q;
    addr_d    = addr_q;
    words_d   = words_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_go) begin
      len_hi_d = 8'd0;
      rem_d    = 18'd0;
      csum_d   = 8'd0;
      addr_d   = 32'd0;
      words_d  = '0;
    end else if (accept) begin
      case (state_q)
        BS_LEN_HI: len_hi_d = rx_data;
        BS_LEN_LO: rem_d    = {len_w, 2'b00};
        BS_DATA: begin
          rem_d  = rem_q - 18'd1;
          csum_d = csum_q ^ rx_data;
        end
        default: ;
      endcase
    end
    if (word_vld) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = word;
      addr_d    = addr_q + 32'd4;
      words_d   = words_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_hi_q  <= 8'd0;
      rem_q     <= 18'd0;
      csum_q    <= 8'd0;
      addr_q    <= 32'd0;
      words_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'd0;
      wr_data_q <= '0;
    end else begin
      len_hi_q  <= len_hi_d;
      rem_q     <= rem_d;
      csum_q    <= csum_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = words_q;

endmodule
